bfloat_sub_pipe: RTL and testbench
==================================

BFLOAT_SUB_PIPE -- requirements
Module: bfloat_sub_pipe

Interface
REQ-001 Parameter NAN_VALUE, default 16'h7FC0, is the result for any NaN/Inf input.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 a  input  16  bfloat16 minuend {sign, exp[7:0], mant[6:0]}.
REQ-007 b  input  16  bfloat16 subtrahend.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out  output  16  bfloat16 result of a - b.

Function
REQ-011 A transfer SHALL occur on any edge where the valid and ready of that port are both high; a and b are sampled only on an input transfer.
REQ-012 The pipeline SHALL have 3 register stages (S1 unpack/swap, S2 align/add, S3 normalize/pack); out_valid rises 3 cycles after an input transfer when out_ready is held high.
REQ-013 in_ready SHALL equal (!S3_valid || out_ready); a stall freezes all stages together, and results emerge in input order with none lost or duplicated.
REQ-014 out and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 Sustained throughput SHALL be one result per cycle when in_valid and out_ready are both held high.
REQ-016 S1: operation is a + (-b); b sign inverted; exp=0x00 operand treated as zero (denormals flushed); otherwise mantissa = {1, mant}, 8 bits.
REQ-017 S1: operand with larger {exp, mant} magnitude becomes X, other Y; on equal magnitude X=a; d = exp_X - exp_Y.
REQ-018 S2: Y mantissa shifted right by d, truncated with no guard/round bits; d>=8 gives 0.
REQ-019 S2: equal effective signs add to a 9-bit sum; unequal signs give X_m - Y_m (never negative); result sign = sign of X.
REQ-020 S3: sum bit8 set -> shift right 1, exp+1; else shift left by leading-zero count of bits[7:0], exp - count.
REQ-021 S3: zero mantissa result SHALL produce 16'h0000.
REQ-022 S3: normalized exponent <= 0 SHALL produce {sign_X, 15'h0000}.
REQ-023 S3: normalized exponent >= 255 SHALL produce {sign_X, 8'hFF, 7'h00}.
REQ-024 Either input with exp=0xFF SHALL produce NAN_VALUE, overriding REQ-021..023.
REQ-025 Both inputs zero (exp=0x00) SHALL produce 16'h0000.
REQ-026 Rounding SHALL be truncation toward zero throughout; no rounding increment.

Reset
REQ-027 While rst_n=0: all stage valids cleared, out_valid=0, out=16'h0000, in_ready=1.
REQ-028 Assertion mid-operation SHALL discard all in-flight results immediately; no result for them appears after release.
REQ-029 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 a=16'h4040, b=16'h3F80, out_ready=1 -> out=16'h4000 with out_valid exactly 3 cycles after acceptance.
REQ-031 a=16'h3F80, b=16'h4000 -> out=16'hBF80; a=16'h3F80, b=16'h3F80 -> out=16'h0000.
REQ-032 a=16'h7F7F, b=16'hFF7F -> out=16'h7F80; a=16'h7F80 with any b -> out=16'h7FC0; a=16'h0001, b=16'h0000 -> out=16'h0000.
REQ-033 Back-to-back stream of 6 pairs with out_ready low for cycles 4-8 -> in_ready low while S3 is full and out_ready is low; all 6 results are correct, in order and stable while stalled.
REQ-034 rst_n pulsed low with 3 results in flight -> out_valid=0 immediately; no stale result after release; next pair yields a correct result at latency 3.

Source files
------------

// File: rtl/bfloat_sub_pipe_if.sv
// Handshake and operand/result bus for the bfloat16 subtract pipeline.
// The slave side belongs to the pipeline and the master side belongs to the producer/consumer.
interface bfloat_sub_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out;

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out
   );

   modport master (
      output in_valid,
      output a,
      output b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out
   );
endinterface

// File: rtl/bfloat_sub_pipe.sv
// Three-stage bfloat16 subtractor computing out = a - b.
// It flushes denormals, truncates every result, and saturates on overflow; any NaN or Inf operand gives NAN_VALUE.
module bfloat_sub_pipe #(
   parameter logic [15:0] NAN_VALUE = 16'h7FC0
) (
   input logic              clk,
   input logic              rst_n,
   bfloat_sub_pipe_if.slave bus
);

   logic        r_s1Valid;
   logic        r_s1Special;
   logic        r_s1SignX;
   logic        r_s1SignY;
   logic [7:0]  r_s1ExpX;
   logic [7:0]  r_s1MantX;
   logic [7:0]  r_s1MantY;
   logic [7:0]  r_s1Diff;

   logic        r_s2Valid;
   logic        r_s2Special;
   logic        r_s2Sign;
   logic [7:0]  r_s2Exp;
   logic [8:0]  r_s2Sum;

   logic        r_s3Valid;
   logic [15:0] r_s3Out;

   logic        w_advance;
   logic [7:0]  w_aExp;
   logic [7:0]  w_bExp;
   logic [7:0]  w_aMant;
   logic [7:0]  w_bMant;
   logic        w_aSign;
   logic        w_bSign;
   logic        w_aIsX;
   logic        w_special;
   logic        w_xSign;
   logic        w_ySign;
   logic [7:0]  w_xExp;
   logic [7:0]  w_yExp;
   logic [7:0]  w_xMant;
   logic [7:0]  w_yMant;
   logic [7:0]  w_shiftY;
   logic [8:0]  w_sum;
   logic [3:0]  w_lzc;
   logic [6:0]  w_normMant;
   logic [9:0]  w_normExp;
   logic        w_underflow;
   logic        w_overflow;
   logic [15:0] w_packed;

   // All stages advance together, so a full output register stalls the whole pipe.
   assign w_advance     = !r_s3Valid || bus.out_ready;
   assign bus.in_ready  = w_advance;
   assign bus.out_valid = r_s3Valid;
   assign bus.out       = r_s3Out;

   assign w_aExp    = bus.a[14:7];
   assign w_bExp    = bus.b[14:7];
   assign w_aMant   = (w_aExp == 8'h00) ? 8'h00 : {1'b1, bus.a[6:0]};
   assign w_bMant   = (w_bExp == 8'h00) ? 8'h00 : {1'b1, bus.b[6:0]};
   assign w_aSign   = bus.a[15];
   assign w_bSign   = ~bus.b[15];
   assign w_aIsX    = (bus.a[14:0] >= bus.b[14:0]);
   assign w_special = (w_aExp == 8'hFF) || (w_bExp == 8'hFF);

   assign w_xSign = w_aIsX ? w_aSign : w_bSign;
   assign w_ySign = w_aIsX ? w_bSign : w_aSign;
   assign w_xExp  = w_aIsX ? w_aExp  : w_bExp;
   assign w_yExp  = w_aIsX ? w_bExp  : w_aExp;
   assign w_xMant = w_aIsX ? w_aMant : w_bMant;
   assign w_yMant = w_aIsX ? w_bMant : w_aMant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid   <= 1'b0;
         r_s1Special <= 1'b0;
         r_s1SignX   <= 1'b0;
         r_s1SignY   <= 1'b0;
         r_s1ExpX    <= 8'h00;
         r_s1MantX   <= 8'h00;
         r_s1MantY   <= 8'h00;
         r_s1Diff    <= 8'h00;
      end else if (w_advance) begin
         r_s1Valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1Special <= w_special;
            r_s1SignX   <= w_xSign;
            r_s1SignY   <= w_ySign;
            r_s1ExpX    <= w_xExp;
            r_s1MantX   <= w_xMant;
            r_s1MantY   <= w_yMant;
            r_s1Diff    <= w_xExp - w_yExp;
         end
      end
   end

   // X always has the larger magnitude, so the difference branch cannot go negative.
   assign w_shiftY = (r_s1Diff > 8'd7) ? 8'h00 : (r_s1MantY >> r_s1Diff[2:0]);
   assign w_sum    = (r_s1SignX == r_s1SignY) ? ({1'b0, r_s1MantX} + {1'b0, w_shiftY})
                                              : ({1'b0, r_s1MantX} - {1'b0, w_shiftY});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2Valid   <= 1'b0;
         r_s2Special <= 1'b0;
         r_s2Sign    <= 1'b0;
         r_s2Exp     <= 8'h00;
         r_s2Sum     <= 9'h000;
      end else if (w_advance) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2Special <= r_s1Special;
            r_s2Sign    <= r_s1SignX;
            r_s2Exp     <= r_s1ExpX;
            r_s2Sum     <= w_sum;
         end
      end
   end

   always_comb begin
      w_lzc = 4'd8;
      for (int i = 0; i < 8; i++) begin
         if (r_s2Sum[i]) begin
            w_lzc = 4'(7 - i);
         end
      end
   end

   // The hidden leading one is dropped here, so only the seven fraction bits are kept.
   assign w_normMant  = r_s2Sum[8] ? r_s2Sum[7:1] : (r_s2Sum[6:0] << w_lzc);
   assign w_normExp   = r_s2Sum[8] ? ({2'b00, r_s2Exp} + 10'd1)
                                   : ({2'b00, r_s2Exp} - {6'b000000, w_lzc});
   assign w_underflow = w_normExp[9] || (w_normExp == 10'd0);
   assign w_overflow  = !w_normExp[9] && (w_normExp >= 10'd255);

   always_comb begin
      w_packed = {r_s2Sign, w_normExp[7:0], w_normMant};
      if (r_s2Special) begin
         w_packed = NAN_VALUE;
      end else if (r_s2Sum == 9'h000) begin
         w_packed = 16'h0000;
      end else if (w_underflow) begin
         w_packed = {r_s2Sign, 15'h0000};
      end else if (w_overflow) begin
         w_packed = {r_s2Sign, 8'hFF, 7'h00};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s3Valid <= 1'b0;
         r_s3Out   <= 16'h0000;
      end else if (w_advance) begin
         r_s3Valid <= r_s2Valid;
         if (r_s2Valid) begin
            r_s3Out <= w_packed;
         end
      end
   end

endmodule

// File: tb/tb_bfloat_sub_pipe.sv
// Self-checking bench for bfloat_sub_pipe.
// It uses a scoreboard of accepted pairs, an arithmetic reference model, and hand-computed expected results.
module tb_bfloat_sub_pipe;

   localparam logic [15:0] NAN_VALUE = 16'h7FC0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] hand;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] hand;
      int          acceptEdge;
      bit          stalled;
   } exp_t;

   logic clk;
   logic rst_n;
   bfloat_sub_pipe_if bus();

   bfloat_sub_pipe #(.NAN_VALUE(NAN_VALUE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int          checks = 0;
   int          passes = 0;
   int          edgeCount = 0;
   logic [15:0] curHand = 16'h0000;
   exp_t        expQ[$];
   bit          prevStalled = 1'b0;
   logic [15:0] prevOut = 16'h0000;

   vec_t vecs [15] = '{
      '{16'h4040, 16'h3F80, 16'h4000},
      '{16'h3F80, 16'h4000, 16'hBF80},
      '{16'h3F80, 16'h3F80, 16'h0000},
      '{16'h7F7F, 16'hFF7F, 16'h7F80},
      '{16'h7F80, 16'h1234, 16'h7FC0},
      '{16'h0001, 16'h0000, 16'h0000},
      '{16'h3F80, 16'hBF80, 16'h4000},
      '{16'h4120, 16'h3F80, 16'h4110},
      '{16'h80C0, 16'h8080, 16'h8000},
      '{16'h4000, 16'h3B80, 16'h4000},
      '{16'h3F80, 16'hBC7F, 16'h3F81},
      '{16'h3F80, 16'hFFC0, 16'h7FC0},
      '{16'hC040, 16'h4000, 16'hC0A0},
      '{16'h0080, 16'h0000, 16'h0080},
      '{16'h4000, 16'h0040, 16'h4000}
   };

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCount++;

   // The reference computes a - b from value semantics: it aligns and truncates the smaller operand, then renormalises.
   function automatic logic [15:0] modelSub(input logic [15:0] x, input logic [15:0] y);
      int ea, eb, ma, mb, ex, mx, my, d, yAligned, val, e;
      bit sa, sb, sx, sy;
      logic [15:0] r;
      ea = int'(x[14:7]);
      eb = int'(y[14:7]);
      if (ea == 255 || eb == 255) return NAN_VALUE;
      ma = (ea == 0) ? 0 : 128 + int'(x[6:0]);
      mb = (eb == 0) ? 0 : 128 + int'(y[6:0]);
      sa = x[15];
      sb = ~y[15];
      if (x[14:0] >= y[14:0]) begin
         ex = ea; mx = ma; sx = sa; my = mb; sy = sb; d = ea - eb;
      end else begin
         ex = eb; mx = mb; sx = sb; my = ma; sy = sa; d = eb - ea;
      end
      yAligned = (d >= 8) ? 0 : my / (1 << d);
      val = (sx == sy) ? mx + yAligned : mx - yAligned;
      if (val == 0) return 16'h0000;
      e = ex;
      while (val > 255) begin
         val = val / 2;
         e++;
      end
      while (val < 128) begin
         val = val * 2;
         e--;
      end
      if (e <= 0) return {sx, 15'h0000};
      if (e >= 255) return {sx, 8'hFF, 7'h00};
      r[15]   = sx;
      r[14:7] = 8'(e);
      r[6:0]  = 7'(val);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] hv, output int acc);
      bus.a        = av;
      bus.b        = bv;
      curHand      = hv;
      bus.in_valid = 1'b1;
      acc          = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            acc = edgeCount + 1;
            break;
         end
      end
      if (acc < 0) checkOutput("accept_timeout", 16'(bus.in_ready), 16'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (expQ.size() == 0 && !bus.out_valid) done = 1'b1;
      end
      if (!done) checkOutput("drain_timeout", 16'(expQ.size()), 16'd0);
      @(posedge clk);
      #1;
   endtask

   // The compare process samples mid-cycle, when every transfer that the next edge will make is already decided.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         expQ.delete();
         prevStalled = 1'b0;
      end else begin
         if (bus.in_valid && bus.in_ready)
            expQ.push_back('{bus.a, bus.b, curHand, edgeCount + 1, 1'b0});
         checkOutput("in_ready_rule", 16'(bus.in_ready), 16'(!bus.out_valid || bus.out_ready));
         if (prevStalled) begin
            checkOutput("hold_valid", 16'(bus.out_valid), 16'd1);
            checkOutput("hold_data", bus.out, prevOut);
         end
         if (bus.out_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_out_valid", 16'(bus.out_valid), 16'd0);
            end else if (bus.out_ready) begin
               e = expQ.pop_front();
               checkOutput("result_vs_model", bus.out, modelSub(e.a, e.b));
               checkOutput("result_vs_hand", bus.out, e.hand);
               if (!e.stalled)
                  checkOutput("latency", 16'(edgeCount + 1 - e.acceptEdge), 16'd3);
            end
         end
         if (!bus.out_ready) begin
            foreach (expQ[i]) expQ[i].stalled = 1'b1;
         end
         prevStalled = bus.out_valid && !bus.out_ready;
         prevOut     = bus.out;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc;
      int relEdge;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = 16'h0000;
      bus.b         = 16'h0000;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", 16'(bus.out_valid), 16'd0);
      checkOutput("reset_out", bus.out, 16'h0000);
      checkOutput("reset_in_ready", 16'(bus.in_ready), 16'd1);
      rst_n   = 1'b1;
      relEdge = edgeCount;

      applyStimulus(vecs[0].a, vecs[0].b, vecs[0].hand, acc);
      checkOutput("first_accept_after_reset", 16'(acc - relEdge), 16'd1);
      waitDrain();
      for (int i = 1; i < 6; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].hand, acc);
         waitDrain();
      end

      for (int i = 6; i < 15; i++) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].hand, acc);
      waitDrain();

      fork
         begin
            for (int i = 7; i < 13; i++) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].hand, acc);
         end
         begin
            repeat (4) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      waitDrain();

      for (int i = 0; i < 3; i++) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].hand, acc);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", 16'(bus.out_valid), 16'd0);
      checkOutput("midreset_out", bus.out, 16'h0000);
      checkOutput("midreset_in_ready", 16'(bus.in_ready), 16'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("stale_after_reset", 16'(bus.out_valid), 16'd0);
      end
      @(posedge clk);
      #1;
      applyStimulus(vecs[3].a, vecs[3].b, vecs[3].hand, acc);
      waitDrain();

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
